// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolver, its decoder and the Comparator.
package branch_pkg;

    localparam logic [2:0] CMP_BEQ  = 3'b000;
    localparam logic [2:0] CMP_BGEZ = 3'b001;
    localparam logic [2:0] CMP_BGTZ = 3'b010;
    localparam logic [2:0] CMP_BLEZ = 3'b011;
    localparam logic [2:0] CMP_BLTZ = 3'b100;
    localparam logic [2:0] CMP_BNE  = 3'b101;
    localparam logic [2:0] CMP_BGT  = 3'b110;
    localparam logic [2:0] CMP_NONE = 3'b111;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_BGT    = 6'b010111;

    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_CMP,
        ST_REDIRECT
    } br_state_t;

    // Single-operand compares run against zero on InB.
    function automatic logic uses_zero_b(input logic [2:0] code);
        return code inside {CMP_BGEZ, CMP_BGTZ, CMP_BLEZ, CMP_BLTZ};
    endfunction

endpackage

// File: rtl/branch_decode.sv
// Combinational branch decode: Instruction -> {IsBranch, Control, ZeroB}.
module branch_decode
    import branch_pkg::*;
#(
    parameter logic [5:0] BGT_OPCODE = OP_BGT
) (
    input  logic [31:0] Instruction,
    output logic        IsBranch,
    output logic [2:0]  Control,
    output logic        ZeroB
);

    logic [5:0] opcode;
    logic [4:0] rt;
    logic       unused_fields;

    assign opcode        = Instruction[31:26];
    assign rt            = Instruction[20:16];
    assign unused_fields = ^{Instruction[25:21], Instruction[15:0]};

    always_comb begin
        Control = CMP_NONE;
        case (opcode)
            OP_BEQ:    Control = CMP_BEQ;
            OP_BNE:    Control = CMP_BNE;
            OP_BLEZ:   Control = CMP_BLEZ;
            OP_BGTZ:   Control = CMP_BGTZ;
            OP_REGIMM: begin
                if (rt == RT_BGEZ)
                    Control = CMP_BGEZ;
                else if (rt == RT_BLTZ)
                    Control = CMP_BLTZ;
            end
            default: begin
                if (opcode == BGT_OPCODE)
                    Control = CMP_BGT;
            end
        endcase
    end

    assign IsBranch = (Control != CMP_NONE);
    assign ZeroB    = uses_zero_b(Control);

endmodule

// File: rtl/branch_resolver.sv
// ID-stage branch resolver: drives the Comparator, captures its Result and issues the PC redirect/flush.
// Optional taken/not-taken counters are enabled with `define BRANCH_STATS_EN.
module branch_resolver
    import branch_pkg::*;
#(
    parameter logic [5:0]  BGT_OPCODE = OP_BGT,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [31:0]       Instruction,
    input  logic              InstrValid,
    input  logic [ADDR_W-1:0] PCPlus4,
    input  logic              Stall,
    input  logic              CmpResult,
    output logic [2:0]        CmpControl,
    output logic              CmpZeroB,
    output logic              IsBranch,
    output logic              Busy,
    output logic              Redirect,
    output logic [ADDR_W-1:0] BranchTarget,
    output logic              Flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       TakenCount,
    output logic [31:0]       NotTakenCount
`endif
);

    br_state_t         state;
    logic [2:0]        ctl_q;
    logic              zb_q;
    logic [2:0]        dec_ctl;
    logic              dec_zb;
    logic              dec_br;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] target;

    branch_decode #(
        .BGT_OPCODE(BGT_OPCODE)
    ) u_decode (
        .Instruction(Instruction),
        .IsBranch   (dec_br),
        .Control    (dec_ctl),
        .ZeroB      (dec_zb)
    );

    assign IsBranch = dec_br;
    assign offset   = {{(ADDR_W-18){Instruction[15]}}, Instruction[15:0], 2'b00};
    assign target   = PCPlus4 + offset;
    assign Busy     = (state != ST_IDLE);

    // In IDLE the comparator must see the code in the acceptance cycle itself.
    assign CmpControl = (state == ST_IDLE) ? dec_ctl : ctl_q;
    assign CmpZeroB   = (state == ST_IDLE) ? dec_zb  : zb_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= ST_IDLE;
            ctl_q        <= CMP_NONE;
            zb_q         <= 1'b0;
            BranchTarget <= '0;
            Redirect     <= 1'b0;
            Flush        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (InstrValid && dec_br && !Stall) begin
                        ctl_q        <= dec_ctl;
                        zb_q         <= dec_zb;
                        BranchTarget <= target;
                        state        <= ST_WAIT_CMP;
                    end
                end
                ST_WAIT_CMP: begin
                    if (CmpResult) begin
                        Redirect <= 1'b1;
                        Flush    <= 1'b1;
                        state    <= ST_REDIRECT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REDIRECT: begin
                    if (!Stall) begin
                        Redirect <= 1'b0;
                        Flush    <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            TakenCount    <= '0;
            NotTakenCount <= '0;
        end else if (state == ST_WAIT_CMP) begin
            if (CmpResult)
                TakenCount <= TakenCount + 32'd1;
            else
                NotTakenCount <= NotTakenCount + 32'd1;
        end
    end
`endif

endmodule
